// File: rtl/agc_pkg.sv
// Shared constants and FSM state encoding for the AGC gain loop and its serial link.
package agc_pkg;

    localparam int FRAME_W = 16;

    // Defaults shared with the histogram readout side.
    localparam logic [7:0] AGC_TARGET_DEF   = 8'd86;
    localparam logic [7:0] AGC_DEADBAND_DEF = 8'd6;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        END,
        GAP
    } spi_state_e;

endpackage

// File: rtl/agc_spi_tx.sv
// 16-bit MSB-first serial shifter: cs_n framing, sclk idle low, mosi changes on sclk fall.
module agc_spi_tx
    import agc_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] data,
    output logic               cs_n,
    output logic               sclk,
    output logic               mosi,
    output logic               busy,
    output spi_state_e         state
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [4:0] HALF_LAST = 5'(2 * FRAME_W - 1);

    logic [CW-1:0]      cnt;
    logic [4:0]         half;
    logic [FRAME_W-1:0] shreg;
    logic               half_done;

    assign half_done = (cnt == CNT_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            half  <= '0;
            shreg <= '0;
            cs_n  <= 1'b1;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state <= START;
                        shreg <= data;
                        cs_n  <= 1'b0;
                        mosi  <= data[FRAME_W-1];
                    end
                end
                START: begin
                    if (half_done) begin
                        cnt   <= '0;
                        half  <= '0;
                        sclk  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // Even half-periods are sclk high, odd are low; the last low half stays in SHIFT.
                    if (half_done) begin
                        cnt <= '0;
                        if (half == HALF_LAST) begin
                            state <= END;
                        end else begin
                            half <= half + 1'b1;
                            sclk <= ~sclk;
                            if (sclk) begin
                                shreg <= {shreg[FRAME_W-2:0], 1'b0};
                                mosi  <= shreg[FRAME_W-2];
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                END: begin
                    if (half_done) begin
                        cnt   <= '0;
                        cs_n  <= 1'b1;
                        mosi  <= 1'b0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (half_done) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/agc_gain_loop.sv
// Histogram-driven RF gain loop with deadband and coarse/fine steps, writing each new code over SPI.
// Optional manual override ports are added when AGC_MANUAL_EN is defined.
module agc_gain_loop
    import agc_pkg::*;
#(
    parameter logic [7:0]        TARGET    = AGC_TARGET_DEF,
    parameter logic [7:0]        DEADBAND  = AGC_DEADBAND_DEF,
    parameter logic [7:0]        COARSE    = 8'd32,
    parameter int                GAIN_W    = 6,
    parameter logic [GAIN_W-1:0] GAIN_INIT = GAIN_W'(32),
    parameter logic [GAIN_W-1:0] GAIN_MAX  = GAIN_W'(63),
    parameter logic [7:0]        REG_ADDR  = 8'h0C,
    parameter int                CLK_DIV   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        h_mag,
    input  logic              h_valid,
`ifdef AGC_MANUAL_EN
    input  logic              manual_en,
    input  logic [GAIN_W-1:0] manual_gain,
`endif
    output logic [GAIN_W-1:0] gain,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              busy
);

    localparam int SW = GAIN_W + 2;

    logic signed [9:0]    err;
    logic [9:0]           err_abs;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] sum;
    logic [GAIN_W-1:0]    loop_gain;
    logic [GAIN_W-1:0]    next_gain;
    logic                 upd;

    logic               req;
    logic               pending;
    logic               spi_busy;
    logic [FRAME_W-1:0] frame;
    spi_state_e         spi_state;

    always_comb begin
        err     = $signed({2'b00, h_mag}) - $signed({2'b00, TARGET});
        err_abs = err[9] ? $unsigned(-err) : $unsigned(err);
        step    = '0;
        // Positive error means too much signal, so the gain steps down.
        if (err_abs > {2'b00, DEADBAND}) begin
            step = (err_abs > {2'b00, COARSE}) ? SW'(2) : SW'(1);
            if (!err[9]) step = -step;
        end
        sum = $signed({2'b00, gain}) + step;
        if (sum[SW-1])
            loop_gain = '0;
        else if (sum > $signed({2'b00, GAIN_MAX}))
            loop_gain = GAIN_MAX;
        else
            loop_gain = sum[GAIN_W-1:0];
`ifdef AGC_MANUAL_EN
        if (manual_en) begin
            next_gain = (manual_gain > GAIN_MAX) ? GAIN_MAX : manual_gain;
            upd       = 1'b1;
        end else begin
            next_gain = loop_gain;
            upd       = h_valid;
        end
`else
        next_gain = loop_gain;
        upd       = h_valid;
`endif
    end

    // pending is consumed on the cycle the shifter accepts it (start held while idle).
    always_ff @(posedge clk) begin
        if (reset) begin
            gain    <= GAIN_INIT;
            req     <= 1'b0;
            pending <= 1'b1;
        end else begin
            req <= 1'b0;
            if (upd && (next_gain != gain)) begin
                gain <= next_gain;
                req  <= 1'b1;
            end
            pending <= req | (pending & (spi_state != IDLE));
        end
    end

    assign frame = {REG_ADDR, 8'(gain)};
    assign busy  = pending | spi_busy;

    agc_spi_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_tx (
        .clk   (clk),
        .reset (reset),
        .start (pending),
        .data  (frame),
        .cs_n  (spi_cs_n),
        .sclk  (spi_sclk),
        .mosi  (spi_mosi),
        .busy  (spi_busy),
        .state (spi_state)
    );

endmodule

// File: tb/tb_agc_gain_loop.sv
// Directed bench for agc_gain_loop: gain stepping, saturation, frame content/timing and reset behaviour.
module tb_agc_gain_loop;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] h_mag = 8'd0;
    logic       h_valid = 1'b0;
    logic [5:0] gain;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          len_q[$];

    logic        prev_sclk = 1'b0;
    bit          in_frame = 1'b0;
    int          low_cnt = 0;
    int          nbits = 0;
    logic [15:0] word = '0;

    agc_gain_loop dut (
        .clk      (clk),
        .reset    (reset),
        .h_mag    (h_mag),
        .h_valid  (h_valid),
        .gain     (gain),
        .spi_cs_n (cs_n),
        .spi_sclk (sclk),
        .spi_mosi (mosi),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Frame capture: shift mosi on sclk rise while cs_n is low, record cs_n-low length.
    always @(negedge clk) begin
        if (cs_n === 1'b0) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                low_cnt  = 0;
                nbits    = 0;
                word     = '0;
            end
            low_cnt++;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                word = {word[14:0], mosi};
                nbits++;
            end
        end else if (in_frame) begin
            in_frame = 1'b0;
            got_q.push_back(word);
            len_q.push_back(low_cnt);
        end
        prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] m);
        h_mag   = m;
        h_valid = 1'b1;
        @(negedge clk);
        h_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({tag, " busy low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_frame(input logic [15:0] f, input string tag);
        int n = 0;
        logic [15:0] e;
        exp_q.push_back(f);
        while (got_q.size() == 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        check({tag, " frame present"}, {31'd0, got_q.size() != 0}, 32'd1);
        if (got_q.size() != 0) begin
            check({tag, " frame"}, {16'd0, got_q.pop_front()}, {16'd0, e});
            check({tag, " cs_n low cycles"}, len_q.pop_front(), 32'd136);
        end
    endtask

    task automatic expect_last(input logic [15:0] f, input string tag);
        check({tag, " frames seen"}, {31'd0, got_q.size() != 0}, 32'd1);
        if (got_q.size() != 0)
            check({tag, " last frame"}, {16'd0, got_q[$]}, {16'd0, f});
        got_q.delete();
        len_q.delete();
    endtask

    task automatic expect_none(input string tag);
        cycles(20);
        check({tag, " no frame"}, got_q.size(), 32'd0);
        check({tag, " busy low"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;

        // Reset state
        reset = 1'b1;
        cycles(3);
        check("rst gain", {26'd0, gain}, 32'd32);
        check("rst cs_n", {31'd0, cs_n}, 32'd1);
        check("rst sclk", {31'd0, sclk}, 32'd0);
        check("rst mosi", {31'd0, mosi}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd1);

        // Reset release: initial frame within 3 cycles
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cs_n !== 1'b0 && n < 3);
        check("rst frame start", {31'd0, cs_n}, 32'd0);
        expect_frame(16'h0C20, "rst");
        wait_idle("rst");

        // Inside deadband
        pulse(8'd86);
        check("db 86 gain", {26'd0, gain}, 32'd32);
        pulse(8'd92);
        check("db 92 gain", {26'd0, gain}, 32'd32);
        pulse(8'd80);
        check("db 80 gain", {26'd0, gain}, 32'd32);
        expect_none("deadband");

        // Fine step down, with request-to-cs_n latency
        pulse(8'd100);
        check("fine gain", {26'd0, gain}, 32'd31);
        check("lat t0 cs_n", {31'd0, cs_n}, 32'd1);
        @(negedge clk);
        check("lat t1 cs_n", {31'd0, cs_n}, 32'd1);
        check("lat t1 busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("lat t2 cs_n", {31'd0, cs_n}, 32'd0);
        expect_frame(16'h0C1F, "fine");
        wait_idle("fine");

        // Coarse step down
        pulse(8'd130);
        check("coarse gain", {26'd0, gain}, 32'd29);
        expect_frame(16'h0C1D, "coarse");
        wait_idle("coarse");

        // Ramp down to 1, then saturate at 0
        repeat (14) begin
            pulse(8'd200);
            cycles(1);
        end
        check("ramp down gain", {26'd0, gain}, 32'd1);
        wait_idle("ramp down");
        expect_last(16'h0C01, "ramp down");
        pulse(8'd200);
        check("sat low gain", {26'd0, gain}, 32'd0);
        expect_frame(16'h0C00, "sat low");
        wait_idle("sat low");
        pulse(8'd200);
        check("sat low hold gain", {26'd0, gain}, 32'd0);
        expect_none("sat low hold");

        // Ramp up to 62, then saturate at 63
        repeat (31) begin
            pulse(8'd0);
            cycles(1);
        end
        check("ramp up gain", {26'd0, gain}, 32'd62);
        wait_idle("ramp up");
        expect_last(16'h0C3E, "ramp up");
        pulse(8'd0);
        check("sat high gain", {26'd0, gain}, 32'd63);
        expect_frame(16'h0C3F, "sat high");
        wait_idle("sat high");
        pulse(8'd0);
        check("sat high hold gain", {26'd0, gain}, 32'd63);
        expect_none("sat high hold");

        // Back-to-back updates during the reset frame: only the final gain follows
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        n = 0;
        while (cs_n !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("b2b frame active", {31'd0, cs_n}, 32'd0);
        pulse(8'd40);
        cycles(9);
        pulse(8'd40);
        check("b2b gain", {26'd0, gain}, 32'd36);
        expect_frame(16'h0C20, "b2b first");
        expect_frame(16'h0C24, "b2b second");
        wait_idle("b2b");
        expect_none("b2b");

        // Mid-frame reset at bit 7
        pulse(8'd100);
        check("mid gain", {26'd0, gain}, 32'd35);
        n = 0;
        while (!(in_frame && nbits >= 8) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("mid reached bit 7", {31'd0, in_frame && nbits >= 8}, 32'd1);
        cycles(5);
        reset = 1'b1;
        @(negedge clk);
        check("mid rst cs_n", {31'd0, cs_n}, 32'd1);
        check("mid rst sclk", {31'd0, sclk}, 32'd0);
        check("mid rst mosi", {31'd0, mosi}, 32'd0);
        check("mid rst gain", {26'd0, gain}, 32'd32);
        check("mid rst busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mid aborted frame short", {31'd0, len_q.size() == 1 && len_q[0] < 136}, 32'd1);
        got_q.delete();
        len_q.delete();
        expect_frame(16'h0C20, "post reset");
        wait_idle("post reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
